// File: rtl/mw_add_pkg.sv
// mw_add_pkg: state encoding and byte width shared by mw_add_seq and its adder.
package mw_add_pkg;
    localparam int BYTE_W = 8;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/mw_add_seq_if.sv
// mw_add_seq_if: request/result handshake bundle; i_sub exists only with MW_ADD_SEQ_SUB_EN.
interface mw_add_seq_if #(parameter int NBYTES = 4);
    import mw_add_pkg::*;
    logic                     i_valid;
    logic                     o_ready;
    logic [BYTE_W*NBYTES-1:0] i_a;
    logic [BYTE_W*NBYTES-1:0] i_b;
    logic                     i_cin;
`ifdef MW_ADD_SEQ_SUB_EN
    logic                     i_sub;
`endif
    logic                     o_valid;
    logic                     i_ready;
    logic [BYTE_W*NBYTES-1:0] o_sum;
    logic                     o_cout;
    modport slave (
        input  i_valid, i_a, i_b, i_cin, i_ready,
`ifdef MW_ADD_SEQ_SUB_EN
        input  i_sub,
`endif
        output o_ready, o_valid, o_sum, o_cout
    );
    modport master (
        output i_valid, i_a, i_b, i_cin, i_ready,
`ifdef MW_ADD_SEQ_SUB_EN
        output i_sub,
`endif
        input  o_ready, o_valid, o_sum, o_cout
    );
endinterface

// File: rtl/mw_add_seq_adder.sv
// adder: plain 8-bit adder with carry-in and no carry-out.
module adder
    import mw_add_pkg::*;
(
    input  logic [BYTE_W-1:0] i_a,
    input  logic [BYTE_W-1:0] i_b,
    input  logic              i_cin,
    output logic [BYTE_W-1:0] o_s
);
    assign o_s = i_a + i_b + BYTE_W'(i_cin);
endmodule

// File: rtl/mw_add_seq.sv
// mw_add_seq: byte-serial wide adder through one 8-bit adder, LSB first.
// Define MW_ADD_SEQ_SUB_EN to add i_sub (A-B computed as A+~B+1).
module mw_add_seq
    import mw_add_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input logic         i_clk,
    input logic         i_rst,
    mw_add_seq_if.slave bus
);
    localparam int W     = BYTE_W * NBYTES;
    localparam int IDX_W = NBYTES > 1 ? $clog2(NBYTES) : 1;
    state_t            r_state, w_next;
    logic [W-1:0]      r_a, r_b, r_sum, w_b_in;
    logic [IDX_W-1:0]  r_idx;
    logic              r_carry, r_valid, r_live;
    logic              w_accept, w_last, w_handshake, w_cin0, w_cout;
    logic [BYTE_W-1:0] w_a_byte, w_b_byte, w_s;
`ifdef MW_ADD_SEQ_SUB_EN
    assign w_b_in = bus.i_sub ? ~bus.i_b : bus.i_b;
    assign w_cin0 = bus.i_sub | bus.i_cin;
`else
    assign w_b_in = bus.i_b;
    assign w_cin0 = bus.i_cin;
`endif
    assign w_accept    = r_state == IDLE && r_live && bus.i_valid;
    assign w_last      = r_idx == IDX_W'(NBYTES - 1);
    assign w_handshake = r_valid && bus.i_ready;
    assign w_a_byte    = r_a[r_idx*BYTE_W +: BYTE_W];
    assign w_b_byte    = r_b[r_idx*BYTE_W +: BYTE_W];
    // The adder has no carry port, so recover it from the operand and sum MSBs.
    assign w_cout = (w_a_byte[BYTE_W-1] & w_b_byte[BYTE_W-1]) |
                    ((w_a_byte[BYTE_W-1] ^ w_b_byte[BYTE_W-1]) & ~w_s[BYTE_W-1]);
    adder u_adder (
        .i_a   (w_a_byte),
        .i_b   (w_b_byte),
        .i_cin (r_carry),
        .o_s   (w_s)
    );
    always_comb begin
        w_next = r_state == IDLE ? (w_accept ? RUN : IDLE) :
                 r_state == RUN  ? (w_last ? DONE : RUN) :
                 (w_handshake ? IDLE : DONE);
    end
    // r_live keeps o_ready low until the first edge after reset release.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_valid <= 1'b0;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
            r_valid <= r_state == DONE && !w_handshake;
            if (w_accept) begin
                r_a     <= bus.i_a;
                r_b     <= w_b_in;
                r_carry <= w_cin0;
                r_idx   <= '0;
            end else if (r_state == RUN) begin
                r_sum[r_idx*BYTE_W +: BYTE_W] <= w_s;
                r_carry <= w_cout;
                r_idx   <= r_idx + 1'b1;
            end
        end
    end
    assign bus.o_ready = r_state == IDLE && r_live;
    assign bus.o_valid = r_valid;
    assign bus.o_sum   = r_sum;
    assign bus.o_cout  = r_carry;
endmodule

// File: tb/tb_mw_add_seq.sv
// tb_mw_add_seq: scoreboard bench for mw_add_seq; sub cases run with MW_ADD_SEQ_SUB_EN.
module tb_mw_add_seq;
    localparam int NB = 4;
    localparam int W  = 8 * NB;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    logic [W:0] sb_q[$];
    always #5 clk = ~clk;
    mw_add_seq_if #(.NBYTES(NB)) bus();
    mw_add_seq #(.NBYTES(NB)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
        int t;
        logic [W:0] e;
        t = 0;
        while (!bus.o_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("ready_wait", 64'(bus.o_ready), 64'd1);
        bus.i_valid = 1'b1;
        bus.i_a     = a;
        bus.i_b     = b;
        bus.i_cin   = cin;
        e = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
`ifdef MW_ADD_SEQ_SUB_EN
        bus.i_sub = sub;
        if (sub) e = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
`else
        if (sub) $display("note: sub request ignored without MW_ADD_SEQ_SUB_EN");
`endif
        sb_q.push_back(e);
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask
    task automatic recv(input int hold, input string tag, input logic noise);
        int cyc;
        logic [W:0] e;
        cyc = 0;
        bus.i_ready = 1'b0;
        while (!bus.o_valid && cyc < 20) begin
            if (noise) begin
                bus.i_valid = 1'b1;
                bus.i_a     = $urandom;
                bus.i_b     = $urandom;
            end
            @(negedge clk);
            cyc++;
        end
        bus.i_valid = 1'b0;
        check({tag, "_lat"}, 64'(cyc), 64'(NB + 1));
        e = sb_q.size() != 0 ? sb_q.pop_front() : 'x;
        check({tag, "_res"}, 64'({bus.o_ready, bus.o_valid, bus.o_cout, bus.o_sum}), 64'({2'b01, e}));
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check({tag, "_hold"}, 64'({bus.o_ready, bus.o_valid, bus.o_cout, bus.o_sum}), 64'({2'b01, e}));
        end
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_ready = 1'b0;
        check({tag, "_post"}, 64'({bus.o_ready, bus.o_valid}), 64'd2);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.i_valid = 1'b0;
        bus.i_a     = '0;
        bus.i_b     = '0;
        bus.i_cin   = 1'b0;
        bus.i_ready = 1'b0;
`ifdef MW_ADD_SEQ_SUB_EN
        bus.i_sub = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_out", 64'({bus.o_ready, bus.o_valid, bus.o_cout, bus.o_sum}), 64'd0);
        rst = 1'b0;
        #1;
        check("rdy_rel", 64'(bus.o_ready), 64'd0);
        @(negedge clk);
        check("rdy_up", 64'(bus.o_ready), 64'd1);
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0); recv(0, "wrap", 1'b0);
        send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0); recv(0, "cin", 1'b0);
        send(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0); recv(1, "zero", 1'b0);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0); recv(0, "max", 1'b0);
        send(32'hA5A5_0F0F, 32'h5A5A_F0F1, 1'b0, 1'b0); recv(3, "hold", 1'b0);
        send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0); recv(0, "noise", 1'b1);
`ifdef MW_ADD_SEQ_SUB_EN
        send(32'd5, 32'd7, 1'b0, 1'b1); recv(0, "sub_neg", 1'b0);
        send(32'd7, 32'd5, 1'b0, 1'b1); recv(0, "sub_pos", 1'b0);
        send(32'd9, 32'd9, 1'b0, 1'b1); recv(0, "sub_eq", 1'b0);
        bus.i_sub = 1'b0;
`endif
        for (int i = 0; i < 6; i++) begin
            send($urandom, $urandom, 1'($urandom), 1'b0);
            recv($urandom_range(0, 2), "rand", 1'b0);
        end
        send(32'h8765_4321, 32'h1357_9BDF, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid", 64'({bus.o_ready, bus.o_valid, bus.o_cout, bus.o_sum}), 64'd0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_rel_rdy", 64'(bus.o_ready), 64'd0);
        @(negedge clk);
        check("rst_after", 64'({bus.o_ready, bus.o_valid}), 64'd2);
        send(32'h0102_0304, 32'hF0F0_F0F0, 1'b0, 1'b0); recv(0, "fresh", 1'b0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mw_add_seq.md
MW_ADD_SEQ -- requirements
Module: mw_add_seq

Interface
REQ-001 SHALL have parameter NBYTES, default 4, giving the operand width in bytes (legal values 1..16).
REQ-002 SHALL have port i_clk  input  1  single clock; all state is updated on its rising edge.
REQ-003 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port i_valid  input  1  request valid.
REQ-005 SHALL have port o_ready  output  1  block accepts a request.
REQ-006 SHALL have port i_a  input  8*NBYTES  operand A.
REQ-007 SHALL have port i_b  input  8*NBYTES  operand B.
REQ-008 SHALL have port i_cin  input  1  carry-in for add.
REQ-009 SHALL have port i_sub  input  1  subtract select; present only with MW_ADD_SEQ_SUB_EN.
REQ-010 SHALL have port o_valid  output  1  result valid.
REQ-011 SHALL have port i_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port o_sum  output  8*NBYTES  result.
REQ-013 SHALL have port o_cout  output  1  carry-out of the most significant byte.

Function
REQ-014 SHALL compute a 8*NBYTES-bit sum serially through one 8-bit adder, least significant byte first, one byte per cycle.
REQ-015 SHALL implement the FSM IDLE -> RUN -> DONE -> IDLE.
REQ-016 SHALL assert o_ready only in IDLE.
REQ-017 SHALL, in IDLE with i_valid=1, capture i_a, i_b and the initial carry (i_cin, or 1 when subtracting), clear the byte index, and enter RUN.
REQ-018 SHALL, in RUN, apply byte[idx] of A and B plus the stored carry, write the adder result into o_sum byte[idx], update the carry, and increment idx.
REQ-019 SHALL derive the byte carry-out as (a7&b7)|((a7^b7)&~s7), because the 8-bit adder exports no carry.
REQ-020 SHALL leave RUN for DONE after byte NBYTES-1 is processed.
REQ-021 SHALL therefore assert o_valid exactly NBYTES+1 cycles after the accepting edge; NBYTES=1 gives 2 cycles.
REQ-022 SHALL hold o_valid, o_sum and o_cout stable in DONE until i_ready=1, then return to IDLE on the next edge.
REQ-023 SHALL NOT accept a new request in the cycle of the DONE->IDLE transition, because o_ready is low in DONE.
REQ-024 SHALL ignore i_valid outside IDLE and SHALL NOT alter captured operands while busy.
REQ-025 SHALL ignore i_ready outside DONE.
REQ-026 SHALL wrap the sum modulo 2^(8*NBYTES) and report the overflow bit only on o_cout.

Reset
REQ-027 SHALL, on i_rst=1, immediately force IDLE and set o_valid=0, o_sum=0, o_cout=0, idx=0, carry=0 and the operand registers to 0.
REQ-028 SHALL hold o_ready=0 while i_rst=1 and set o_ready=1 from the first edge after release.
REQ-029 SHALL discard any in-flight operation on reset, with no partial result delivered.

Configuration
REQ-030 SHALL, with MW_ADD_SEQ_SUB_EN defined, provide i_sub; i_sub=1 computes A-B as A+~B+1 and ignores i_cin, with o_cout=1 meaning no borrow.
REQ-031 SHALL, without MW_ADD_SEQ_SUB_EN, omit i_sub and the B inversion logic, with add-only behaviour.

Structure
REQ-032 SHALL place the FSM state enum (IDLE, RUN, DONE) and the BYTE_W=8 constant in the shared package mw_add_pkg.
REQ-033 SHALL instantiate exactly one existing 8-bit adder sub-module (adder) as its only arithmetic resource.

Verification
REQ-034 SHALL cover NBYTES=4: A=0xFFFFFFFF, B=0x00000001, cin=0 -> o_sum=0x00000000, o_cout=1, with o_valid 5 cycles after accept.
REQ-035 SHALL cover A=0x12345678, B=0x11111111, cin=1 -> o_sum=0x2345678A, o_cout=0.
REQ-036 SHALL cover, with SUB_EN, A=5, B=7, i_sub=1 -> o_sum=0xFFFFFFFE, o_cout=0; and A=7, B=5 -> o_sum=0x00000002, o_cout=1.
REQ-037 SHALL cover i_ready held low 3 cycles in DONE -> o_sum, o_cout and o_valid stable; o_ready rises the cycle after the i_ready handshake.
REQ-038 SHALL cover i_rst pulsed 2 cycles after accept -> o_valid=0, o_sum=0; a fresh request after release completes correctly.
REQ-039 SHALL cover i_valid held high through RUN with changing i_a -> result uses only the operands captured at accept.
